tft_power_sequencer: RTL and testbench

Frame-aligned power-up/power-down controller for the 480x272 TFT panel, clocked in the pixel clock domain. It owns the panel control outputs tft_vdd and tft_display, gates the scan-generator data enable, and enables the backlight PWM. Every step is ordered and delayed, with timing in pixel clocks and in frames as counted from the scan generator's new_frame strobe. It sits between the system power request and the panel pins.

---
 rtl/tft_pkg.sv | 46 ++++
 rtl/tft_power_sequencer_counter.sv | 27 ++
 rtl/tft_power_sequencer.sv | 139 +++++++++++++
 tb/tb_tft_power_sequencer.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tft_pkg.sv
// Shared types and panel constants for the TFT power sequencer.
package tft_pkg;

    typedef enum logic [3:0] {
        ST_OFF     = 4'd0,
        ST_VDD     = 4'd1,
        ST_SYNC    = 4'd2,
        ST_DATA    = 4'd3,
        ST_DISP    = 4'd4,
        ST_RUN     = 4'd5,
        ST_BLOFF   = 4'd6,
        ST_DISPOFF = 4'd7,
        ST_DATAOFF = 4'd8
    } tft_state_e;

    localparam int TFT_X_RES      = 480;
    localparam int TFT_Y_RES      = 272;
    localparam int TFT_X_BLANKING = 45;
    localparam int TFT_Y_BLANKING = 16;

    // Totals include the one-clock sync position: 526 x 289 pixel clocks per frame.
    localparam int TFT_H_TOTAL   = TFT_X_RES + TFT_X_BLANKING + 1;
    localparam int TFT_V_TOTAL   = TFT_Y_RES + TFT_Y_BLANKING + 1;
    localparam int TFT_FRAME_CYC = TFT_H_TOTAL * TFT_V_TOTAL;

    typedef struct packed {
        logic vdd;
        logic gate;
        logic disp;
        logic bl;
    } tft_pins_t;

    function automatic tft_pins_t tft_decode(tft_state_e s);
        tft_pins_t p;
        p = '0;
        case (s)
            ST_VDD, ST_SYNC, ST_DATAOFF: p = 4'b1000;
            ST_DATA, ST_DISPOFF:         p = 4'b1100;
            ST_DISP, ST_BLOFF:           p = 4'b1110;
            ST_RUN:                      p = 4'b1111;
            default:                     p = 4'b0000;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/tft_power_sequencer_counter.sv
// Up-counter with synchronous clear and a terminal-count flag against a loaded compare value.
module tft_seq_counter #(
    parameter int WIDTH = 8
) (
    input  logic             tft_clk,
    input  logic             rstb,
    input  logic             clear,
    input  logic             inc,
    input  logic [WIDTH-1:0] last,
    output logic             tc
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge tft_clk) begin
        if (!rstb) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc) begin
            count <= count + WIDTH'(1);
        end
    end

    assign tc = (count == last);

endmodule

// File: rtl/tft_power_sequencer.sv
// Frame-aligned TFT panel power-up/power-down sequencer.
// Optional frame watchdog compiled in with TFT_SEQ_WATCHDOG_EN.
module tft_power_sequencer
    import tft_pkg::*;
#(
    parameter int unsigned VDD_SETTLE_CYC    = 2048,
    parameter int unsigned DISP_DELAY_FRAMES = 2,
    parameter int unsigned BL_DELAY_FRAMES   = 3,
    // One frame rounded up to a power of two.
    parameter int unsigned FRAME_TIMEOUT_CYC = 2 ** $clog2(TFT_FRAME_CYC)
) (
    input  logic       tft_clk,
    input  logic       rstb,
    input  logic       power_req,
    input  logic       new_frame,
    output logic       tft_vdd,
    output logic       tft_display,
    output logic       data_gate,
    output logic       bl_ena,
    output logic       ready,
    output logic       fault,
    output logic [3:0] state
);

    localparam int unsigned CNT_MAX = (VDD_SETTLE_CYC > FRAME_TIMEOUT_CYC) ?
                                      VDD_SETTLE_CYC : FRAME_TIMEOUT_CYC;
    localparam int CNT_W = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(VDD_SETTLE_CYC - 1);
    localparam logic [7:0]       DISP_LAST   = 8'(DISP_DELAY_FRAMES - 1);
    localparam logic [7:0]       BL_LAST     = 8'(BL_DELAY_FRAMES - 1);

    tft_state_e       state_q;
    tft_state_e       state_next;
    tft_pins_t        pins_q;
    logic             ready_q;
    logic [CNT_W-1:0] cyc_last;
    logic             cyc_clear;
    logic             cyc_tc;
    logic [7:0]       frm_last;
    logic             frm_tc;
    logic             state_change;

    assign state_change = (state_next != state_q);

`ifdef TFT_SEQ_WATCHDOG_EN
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(FRAME_TIMEOUT_CYC - 1);

    logic watched;
    logic timeout;
    logic fault_q;

    // The cycle counter doubles as the watchdog in every frame-driven state.
    assign watched   = state_q inside {ST_SYNC, ST_DATA, ST_DISP, ST_RUN, ST_BLOFF, ST_DISPOFF};
    assign cyc_last  = watched ? TIMEOUT_LAST : SETTLE_LAST;
    assign cyc_clear = state_change || (watched && new_frame);
    assign timeout   = watched && cyc_tc && !new_frame;

    always_ff @(posedge tft_clk) begin
        if (!rstb) begin
            fault_q <= 1'b0;
        end else if (timeout) begin
            fault_q <= 1'b1;
        end else if (state_next == ST_OFF && !power_req) begin
            fault_q <= 1'b0;
        end
    end

    assign fault = fault_q;
`else
    assign cyc_last  = SETTLE_LAST;
    assign cyc_clear = state_change;
    assign fault     = 1'b0;
`endif

    assign frm_last = (state_q == ST_DISP) ? BL_LAST : DISP_LAST;

    tft_seq_counter #(.WIDTH(CNT_W)) u_cyc_cnt (
        .tft_clk (tft_clk),
        .rstb    (rstb),
        .clear   (cyc_clear),
        .inc     (1'b1),
        .last    (cyc_last),
        .tc      (cyc_tc)
    );

    tft_seq_counter #(.WIDTH(8)) u_frm_cnt (
        .tft_clk (tft_clk),
        .rstb    (rstb),
        .clear   (state_change),
        .inc     (new_frame),
        .last    (frm_last),
        .tc      (frm_tc)
    );

    always_comb begin
        state_next = state_q;
        case (state_q)
            ST_OFF:     if (power_req && !fault) state_next = ST_VDD;
            ST_VDD:     if (!power_req) state_next = ST_DATAOFF;
                        else if (cyc_tc) state_next = ST_SYNC;
            ST_SYNC:    if (!power_req) state_next = ST_DATAOFF;
                        else if (new_frame) state_next = ST_DATA;
            ST_DATA:    if (!power_req) state_next = ST_DATAOFF;
                        else if (new_frame && frm_tc) state_next = ST_DISP;
            ST_DISP:    if (!power_req) state_next = ST_DISPOFF;
                        else if (BL_DELAY_FRAMES == 0 || (new_frame && frm_tc)) state_next = ST_RUN;
            ST_RUN:     if (!power_req) state_next = ST_BLOFF;
            ST_BLOFF:   if (new_frame) state_next = ST_DISPOFF;
            ST_DISPOFF: if (new_frame && frm_tc) state_next = ST_DATAOFF;
            ST_DATAOFF: if (cyc_tc) state_next = ST_OFF;
            default:    state_next = ST_OFF;
        endcase
`ifdef TFT_SEQ_WATCHDOG_EN
        if (timeout) state_next = ST_DATAOFF;
`endif
    end

    // Pins are decoded from the next state so they move on the same edge as the state.
    always_ff @(posedge tft_clk) begin
        if (!rstb) begin
            state_q <= ST_OFF;
            pins_q  <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_next;
            pins_q  <= tft_decode(state_next);
            ready_q <= (state_next == ST_RUN);
        end
    end

    assign tft_vdd     = pins_q.vdd;
    assign data_gate   = pins_q.gate;
    assign tft_display = pins_q.disp;
    assign bl_ena      = pins_q.bl;
    assign ready       = ready_q;
    assign state       = state_q;

endmodule

// File: tb/tb_tft_power_sequencer.sv
// Bench for tft_power_sequencer: directed test-plan steps plus random traffic against a pin-level ladder model.
module tb_tft_power_sequencer;

    localparam int VDD = 4;
    localparam int DDF = 2;
    localparam int BLF = 1;
    localparam int FT  = 50;
`ifdef TFT_SEQ_WATCHDOG_EN
    localparam bit WD = 1'b1;
`else
    localparam bit WD = 1'b0;
`endif

    logic       tft_clk = 1'b0;
    logic       rstb;
    logic       power_req;
    logic       new_frame;
    logic       tft_vdd, tft_display, data_gate, bl_ena, ready, fault;
    logic [3:0] state;

    int n_cmp = 0;
    int n_err = 0;

    // Model: number of pins asserted (0..4, thermometer vdd/gate/disp/bl) and direction.
    int m_lvl;
    bit m_down;
    bit m_sync;
    bit m_fault;
    bit m_moved;
    int m_cyc;
    int m_frm;
    int m_quiet;

    bit frame_en;
    bit rand_mode;
    int fphase;

    always #5 tft_clk = ~tft_clk;

    tft_power_sequencer #(
        .VDD_SETTLE_CYC    (VDD),
        .DISP_DELAY_FRAMES (DDF),
        .BL_DELAY_FRAMES   (BLF),
        .FRAME_TIMEOUT_CYC (FT)
    ) dut (
        .tft_clk     (tft_clk),
        .rstb        (rstb),
        .power_req   (power_req),
        .new_frame   (new_frame),
        .tft_vdd     (tft_vdd),
        .tft_display (tft_display),
        .data_gate   (data_gate),
        .bl_ena      (bl_ena),
        .ready       (ready),
        .fault       (fault),
        .state       (state)
    );

    task automatic m_go(input int lvl, input bit down, input bit sync);
        m_lvl   = lvl;
        m_down  = down;
        m_sync  = sync;
        m_cyc   = 0;
        m_frm   = 0;
        m_quiet = 0;
        m_moved = 1'b1;
    endtask

    task automatic model_step(input logic rst_n, input logic pr, input logic nf);
        bit watched;
        if (!rst_n) begin
            m_go(0, 1'b0, 1'b0);
            m_fault = 1'b0;
            return;
        end
        m_moved = 1'b0;
        watched = m_down ? (m_lvl >= 2) : (m_lvl >= 2 || (m_lvl == 1 && m_sync));
        if (WD && watched && !nf && m_quiet + 1 == FT) begin
            m_fault = 1'b1;
            m_go(1, 1'b1, 1'b0);
        end else if (m_lvl == 0) begin
            if (pr && !m_fault) m_go(1, 1'b0, 1'b0);
        end else if (!m_down) begin
            if (!pr) m_go((m_lvl >= 3) ? m_lvl - 1 : 1, 1'b1, 1'b0);
            else if (m_lvl == 1 && !m_sync) begin
                if (m_cyc + 1 == VDD) m_go(1, 1'b0, 1'b1);
            end else if (m_lvl == 1) begin
                if (nf) m_go(2, 1'b0, 1'b0);
            end else if (m_lvl == 2) begin
                if (nf && m_frm + 1 == DDF) m_go(3, 1'b0, 1'b0);
            end else if (m_lvl == 3) begin
                if (BLF == 0 || (nf && m_frm + 1 == BLF)) m_go(4, 1'b0, 1'b0);
            end
        end else begin
            if (m_lvl == 3) begin
                if (nf) m_go(2, 1'b1, 1'b0);
            end else if (m_lvl == 2) begin
                if (nf && m_frm + 1 == DDF) m_go(1, 1'b1, 1'b0);
            end else if (m_cyc + 1 == VDD) begin
                m_go(0, 1'b0, 1'b0);
            end
        end
        if (m_lvl == 0 && !pr) m_fault = 1'b0;
        if (!m_moved) begin
            m_cyc++;
            if (nf) begin
                m_frm++;
                m_quiet = 0;
            end else begin
                m_quiet++;
            end
        end
    endtask

    function automatic logic [7:0] exp_pins();
        return {2'b00, m_lvl >= 1, m_lvl >= 2, m_lvl >= 3, m_lvl >= 4, m_lvl == 4, m_fault};
    endfunction

    // Spec numbering: up-ladder OFF,VDD,SYNC,DATA,DISP,RUN then BLOFF,DISPOFF,DATAOFF.
    function automatic logic [7:0] exp_state();
        if (m_lvl == 0) return 8'd0;
        if (m_down) return 8'(9 - m_lvl);
        if (m_lvl == 1) return m_sync ? 8'd2 : 8'd1;
        return 8'(m_lvl + 1);
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        logic nf;
        if (rand_mode) nf = ($urandom_range(0, 5) == 0);
        else nf = frame_en && (fphase == 19);
        fphase = (fphase == 19) ? 0 : fphase + 1;
        new_frame = nf;
        @(posedge tft_clk);
        model_step(rstb, power_req, nf);
        #1;
        chk("pins", {2'b00, tft_vdd, data_gate, tft_display, bl_ena, ready, fault}, exp_pins());
        chk("state", {4'b0000, state}, exp_state());
    endtask

    task automatic wait_state(input logic [3:0] s, input int budget);
        int k;
        k = 0;
        while (state !== s && k < budget) begin
            tick();
            k++;
        end
        chk("wait_state", {4'b0000, state}, {4'b0000, s});
    endtask

    initial begin
        rstb      = 1'b0;
        power_req = 1'b0;
        new_frame = 1'b0;
        frame_en  = 1'b1;
        rand_mode = 1'b0;
        fphase    = 0;
        m_fault   = 1'b0;
        m_go(0, 1'b0, 1'b0);

        repeat (3) tick();
        chk("reset_state", {4'b0000, state}, 8'd0);
        rstb = 1'b1;
        tick();

        // Nominal power-up
        power_req = 1'b1;
        tick();
        chk("vdd_first_edge", {7'd0, tft_vdd}, 8'd1);
        repeat (3) tick();
        chk("vdd_hold", {4'b0000, state}, 8'd1);
        tick();
        chk("sync_entry", {4'b0000, state}, 8'd2);
        wait_state(4'd5, 120);
        chk("run_bl", {6'd0, bl_ena, ready}, 8'd3);

        // Nominal power-down
        power_req = 1'b0;
        tick();
        chk("bl_off_next_edge", {4'b0000, state, bl_ena}, {3'b000, 4'd6, 1'b0});
        wait_state(4'd7, 40);
        chk("disp_low", {7'd0, tft_display}, 8'd0);
        wait_state(4'd8, 60);
        chk("gate_low", {6'd0, data_gate, tft_vdd}, 8'd1);
        repeat (3) tick();
        chk("dataoff_hold", {7'd0, tft_vdd}, 8'd1);
        tick();
        chk("vdd_low", {4'b0000, state, tft_vdd}, 8'd0);

        // Abort after the first frame in DATA
        power_req = 1'b1;
        wait_state(4'd3, 60);
        repeat (20) tick();
        chk("still_data", {4'b0000, state}, 8'd3);
        power_req = 1'b0;
        tick();
        chk("abort_dataoff", {4'b0000, state}, 8'd8);
        repeat (4) tick();
        chk("abort_off", {4'b0000, state}, 8'd0);

        // Re-request during DISPOFF is ignored
        power_req = 1'b1;
        wait_state(4'd5, 200);
        power_req = 1'b0;
        wait_state(4'd7, 40);
        power_req = 1'b1;
        repeat (2) tick();
        chk("rereq_ignored", {4'b0000, state}, 8'd7);
        wait_state(4'd0, 100);
        tick();
        chk("restart_vdd", {4'b0000, state, tft_vdd}, {3'b000, 4'd1, 1'b1});

        // Reset mid-RUN
        wait_state(4'd5, 200);
        rstb = 1'b0;
        tick();
        chk("rst_all_low", {4'b0000, state} | {4'b0000, tft_vdd, data_gate, tft_display, bl_ena}, 8'd0);
        rstb      = 1'b1;
        power_req = 1'b0;
        tick();

`ifdef TFT_SEQ_WATCHDOG_EN
        power_req = 1'b1;
        wait_state(4'd4, 200);
        frame_en = 1'b0;
        repeat (49) tick();
        chk("wd_quiet", {7'd0, fault}, 8'd0);
        tick();
        chk("wd_fault", {3'b000, state, fault}, {3'b000, 4'd8, 1'b1});
        wait_state(4'd0, 20);
        repeat (10) tick();
        chk("wd_hold_off", {3'b000, state, fault}, 8'd1);
        power_req = 1'b0;
        tick();
        chk("wd_clear", {7'd0, fault}, 8'd0);
        frame_en = 1'b1;
`endif

        // Random power requests, frame strobes and occasional resets
        rand_mode = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 39) == 0) power_req = ~power_req;
            rstb = ($urandom_range(0, 599) != 0);
            tick();
        end
        rstb = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
